// File: rtl/serial_full_adder.sv
// rtl/serial_full_adder.sv - bit-serial LSB-first adder with start/ready/done handshake
module serial_full_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic             c;
    logic [CW-1:0]    cnt;
    logic             s_bit;
    logic             c_next;
    logic             last_bit;

    assign s_bit    = a_sr[0] ^ b_sr[0] ^ c;
    assign c_next   = (a_sr[0] & b_sr[0]) | (a_sr[0] & c) | (b_sr[0] & c);
    assign last_bit = (cnt == CW'(WIDTH - 1));

    assign ready = (state == S_IDLE);
    assign busy  = (state == S_SHIFT);
    assign done  = (state == S_DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (start) state_next = S_SHIFT;
            S_SHIFT: if (last_bit) state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // cout/ovf are registered on the final shift so they are already valid while done is high;
    // ovf compares the carry into the MSB (c) with the carry out of it (c_next).
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sr <= '0;
            b_sr <= '0;
            c    <= 1'b0;
            cnt  <= '0;
            sum  <= '0;
            cout <= 1'b0;
            ovf  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        a_sr <= a;
                        b_sr <= b;
                        c    <= cin;
                        cnt  <= '0;
                        sum  <= '0;
                        cout <= 1'b0;
                        ovf  <= 1'b0;
                    end
                end
                S_SHIFT: begin
                    sum  <= {s_bit, sum[WIDTH-1:1]};
                    a_sr <= a_sr >> 1;
                    b_sr <= b_sr >> 1;
                    c    <= c_next;
                    cnt  <= cnt + CW'(1);
                    if (last_bit) begin
                        cout <= c_next;
                        ovf  <= c ^ c_next;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_full_adder.sv
// tb/tb_serial_full_adder.sv - directed scoreboard bench for serial_full_adder
module tb_serial_full_adder;

    localparam int WIDTH = 8;

    typedef struct packed {
        logic [WIDTH-1:0] sum;
        logic             cout;
        logic             ovf;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             ready;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;

    serial_full_adder #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .ready (ready),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                   input logic ci);
        exp_t           r;
        logic [WIDTH:0] t;
        t      = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, ci};
        r.sum  = t[WIDTH-1:0];
        r.cout = t[WIDTH];
        r.ovf  = (x[WIDTH-1] == y[WIDTH-1]) && (t[WIDTH-1] != x[WIDTH-1]);
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic start_op(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                            input logic ci, input bit push);
        chk("ready_before_start", 32'(ready), 32'd1);
        a     = x;
        b     = y;
        cin   = ci;
        start = 1'b1;
        if (push) q.push_back(model(x, y, ci));
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = WIDTH'($urandom);
        b     = WIDTH'($urandom);
        cin   = 1'($urandom);
        @(negedge clk);
        chk("busy_after_accept", 32'(busy), 32'd1);
        chk("ready_after_accept", 32'(ready), 32'd0);
    endtask

    task automatic wait_done(input bit poke);
        int   n;
        bit   seen;
        exp_t e;
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 40) begin
            tick();
            n++;
            if (poke && n == 2) begin
                start = 1'b1;
                a     = 8'hAA;
                b     = 8'h55;
            end else if (poke && n == 3) begin
                start = 1'b0;
            end
            if (done) seen = 1'b1;
        end
        chk("done_seen", 32'(seen), 32'd1);
        chk("latency", 32'(n), 32'(WIDTH));
        chk("busy_in_done", 32'(busy), 32'd0);
        chk("ready_in_done", 32'(ready), 32'd0);
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("sum", 32'(sum), 32'(e.sum));
            chk("cout", 32'(cout), 32'(e.cout));
            chk("ovf", 32'(ovf), 32'(e.ovf));
        end else begin
            chk("scoreboard_nonempty", 32'(q.size()), 32'd1);
        end
        if (poke) start = 1'b1;
        tick();
        start = 1'b0;
        chk("done_one_cycle", 32'(done), 32'd0);
        chk("ready_after_done", 32'(ready), 32'd1);
        chk("busy_after_done", 32'(busy), 32'd0);
        if (seen) chk("sum_held", 32'(sum), 32'(model_last_sum));
    endtask

    logic [WIDTH-1:0] model_last_sum;

    task automatic run_op(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                          input logic ci, input bit poke);
        exp_t e;
        e              = model(x, y, ci);
        model_last_sum = e.sum;
        start_op(x, y, ci, 1'b1);
        wait_done(poke);
    endtask

    initial begin
        int n_done;
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        cin   = 1'b0;
        model_last_sum = '0;
        @(negedge clk);
        tick();
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_sum", 32'(sum), 32'd0);
        chk("rst_cout", 32'(cout), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        rst = 1'b0;
        tick();

        run_op(8'h0F, 8'h01, 1'b0, 1'b0);
        run_op(8'hFF, 8'h01, 1'b0, 1'b0);
        run_op(8'h7F, 8'h01, 1'b0, 1'b0);
        run_op(8'h80, 8'h80, 1'b0, 1'b0);
        run_op(8'h00, 8'h00, 1'b1, 1'b0);
        run_op(8'hFF, 8'hFF, 1'b1, 1'b0);

        // starts while busy and during done must be ignored
        run_op(8'h11, 8'h22, 1'b0, 1'b1);
        n_done = 0;
        for (int i = 0; i < WIDTH + 4; i++) begin
            tick();
            if (done) n_done++;
        end
        chk("no_extra_done", 32'(n_done), 32'd0);
        chk("sum_after_ignored", 32'(sum), 32'h33);

        // abort mid-operation
        start_op(8'hF0, 8'h0F, 1'b0, 1'b0);
        repeat (3) tick();
        rst = 1'b1;
        tick();
        chk("abort_ready", 32'(ready), 32'd1);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_sum", 32'(sum), 32'd0);
        chk("abort_cout", 32'(cout), 32'd0);
        chk("abort_ovf", 32'(ovf), 32'd0);
        rst = 1'b0;
        n_done = 0;
        for (int i = 0; i < WIDTH + 4; i++) begin
            tick();
            if (done) n_done++;
        end
        chk("abort_no_done", 32'(n_done), 32'd0);

        // rst and start together: rst wins
        rst   = 1'b1;
        start = 1'b1;
        a     = 8'h12;
        b     = 8'h34;
        tick();
        start = 1'b0;
        chk("rst_start_ready", 32'(ready), 32'd1);
        chk("rst_start_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        tick();
        chk("rst_start_idle", 32'(ready), 32'd1);

        run_op(8'h3C, 8'hA5, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            logic [WIDTH-1:0] ra;
            logic [WIDTH-1:0] rb;
            ra = WIDTH'($urandom);
            rb = WIDTH'($urandom);
            run_op(ra, rb, 1'($urandom), 1'b0);
        end
        chk("scoreboard_empty", 32'(q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
